cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between functional-unit result producers: ALU, branch ALU, load/store unit, and a spare slot.
- Each producer presents a tagged result. The arbiter grants one per cycle (round-robin) and drives a registered one-cycle CDB broadcast to the reservation stations and the ROB.
- Sits between the per-unit result stages and the CDB consumers.

Parameters:
- NUM_REQ, 4, number of requesters; index 0 is the branch ALU result path.
- SRC_WIDTH, 2, width of the source index; must equal clog2(NUM_REQ).
- TAG_WIDTH, 4, RS/ROB tag width.
- DATA_WIDTH, 32, result width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester result-valid.
- req_tag  in  NUM_REQ*TAG_WIDTH  flattened tags; requester i occupies bits [i*TAG_WIDTH +: TAG_WIDTH].
- req_data  in  NUM_REQ*DATA_WIDTH  flattened results, packed the same way.
- flush  in  1  pipeline flush (branch mispredict).
- grant  out  NUM_REQ  one-hot, combinational; the granted requester may retire its result this cycle.
- cdb_valid  out  1  registered broadcast valid.
- cdb_tag  out  TAG_WIDTH  broadcast tag.
- cdb_data  out  DATA_WIDTH  broadcast data.
- cdb_src  out  SRC_WIDTH  index of the requester that produced the broadcast.

Behaviour:
- Reset (rst low, asynchronous):
  - cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0; round-robin pointer ptr=0.
  - grant forced to 0 while rst is low.
  - Reset mid-broadcast clears the outputs immediately, without waiting for a clock edge.
- Handshake:
  - A requester raises req_valid[i] with tag and data stable, and holds them until it sees grant[i]=1 at a rising edge.
  - It may drop req_valid or present a new result in the cycle after the grant.
  - Dropping req_valid before a grant is illegal; the arbiter does not check it.
- Arbitration (combinational, every cycle):
  - Search order is ptr, ptr+1, …, wrapping modulo NUM_REQ.
  - The first asserted req_valid wins; grant is that one-hot bit, or 0 if none is asserted.
  - Exactly zero or one grant bit per cycle.
- Latency: grant in cycle t → cdb_valid=1 with that requester's tag, data and src in cycle t+1, for exactly one cycle. cdb_valid returns to 0 in the following cycle unless a new grant occurred in cycle t+1.
- Throughput: one broadcast per cycle. There is no backpressure from consumers; the CDB is never stalled.
- Pointer update:
  - On a grant to requester w: ptr <= (w+1) mod NUM_REQ, with wrap from NUM_REQ-1 to 0.
  - No grant: ptr holds.
- Idle cycle: cdb_valid=0; cdb_tag, cdb_data and cdb_src hold their last values (consumers must qualify them with cdb_valid).
- flush=1 in cycle t:
  - grant=0 in cycle t.
  - cdb_valid=0 in cycle t+1, even if a broadcast was registered in cycle t−1 (the register loads invalid).
  - ptr holds.
  - Pending requests are unaffected; requesters drop them themselves on flush. Requests still held are served from cycle t+1.
- No starvation: with every requester continuously requesting, each is granted once every NUM_REQ cycles.

Optional Feature:
- Macro: CDB_BRANCH_PRIORITY_EN.
- Defined:
  - req_valid[0] (branch ALU) always wins, regardless of ptr, so branch resolution is never delayed by a full CDB.
  - A priority grant to requester 0 leaves ptr unchanged.
  - Grants to requesters 1..NUM_REQ-1 follow the normal round-robin search over indices ≠ 0.
- Undefined: requester 0 is arbitrated round-robin exactly like the others.

Test Plan:
- Reset mid-broadcast: cdb_valid=1 when rst drops asynchronously → cdb_valid, cdb_tag, cdb_data, cdb_src read 0 before the next edge. After release, the first grant starts the search from index 0.
- Single request: req_valid=4'b0010, tag 5, data 0x00001234, ptr=0 → grant=4'b0010 in the same cycle; next cycle cdb_valid=1, tag=5, data=0x1234, src=1; the cycle after, cdb_valid=0; ptr=2.
- Full contention: all four requesters held high for 8 cycles from ptr=0 → grants 0,1,2,3,0,1,2,3; cdb_src sequence matches, delayed by one cycle.
- Wrap: ptr=2, req_valid=4'b0011 → grant requester 0, ptr becomes 1; the next cycle with req 1 still high → grant requester 1.
- Flush: req_valid=4'b0100 with flush=1 → grant=0 and cdb_valid=0 next cycle. With flush then deasserted and the request held → grant 2 in the following cycle, broadcast one cycle later.
- CDB_BRANCH_PRIORITY_EN: ptr=2, req_valid=4'b0101 → grant requester 0, ptr stays 2; next cycle with req 2 still high → grant 2, ptr=3. With the macro undefined, the same stimulus grants 2 first.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter that shares the common data bus between
// the functional-unit result producers and registers a one-cycle broadcast.
// Optional macro CDB_BRANCH_PRIORITY_EN: requester 0 (branch ALU) always wins
// and a priority grant leaves the round-robin pointer untouched.
module cdb_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int SRC_WIDTH  = 2,
  parameter int TAG_WIDTH  = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          flush,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          cdb_valid,
  output logic [TAG_WIDTH-1:0]          cdb_tag,
  output logic [DATA_WIDTH-1:0]         cdb_data,
  output logic [SRC_WIDTH-1:0]          cdb_src
);

  logic [SRC_WIDTH-1:0]  ptr_q, ptr_d;
  logic                  cdb_valid_q, cdb_valid_d;
  logic [TAG_WIDTH-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_WIDTH-1:0] cdb_data_q, cdb_data_d;
  logic [SRC_WIDTH-1:0]  cdb_src_q, cdb_src_d;

  logic                  found;
  logic                  prio_win;
  logic [SRC_WIDTH-1:0]  win_idx;
  logic [TAG_WIDTH-1:0]  sel_tag;
  logic [DATA_WIDTH-1:0] sel_data;

  // Pick the winner by scanning from ptr with wrap; reset and flush suppress any grant.
  always_comb begin
    int idx;
    found    = 1'b0;
    prio_win = 1'b0;
    win_idx  = '0;
    sel_tag  = '0;
    sel_data = '0;
    grant    = '0;
    idx      = 0;
    if (rst && !flush) begin
`ifdef CDB_BRANCH_PRIORITY_EN
      if (req_valid[0]) begin
        found    = 1'b1;
        prio_win = 1'b1;
        win_idx  = '0;
        sel_tag  = req_tag[0 +: TAG_WIDTH];
        sel_data = req_data[0 +: DATA_WIDTH];
      end
`endif
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!found && req_valid[idx]) begin
          found    = 1'b1;
          win_idx  = SRC_WIDTH'(idx);
          sel_tag  = req_tag[idx*TAG_WIDTH +: TAG_WIDTH];
          sel_data = req_data[idx*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      if (found) grant[win_idx] = 1'b1;
    end
  end

  // Advance the pointer past a round-robin winner; hold on idle, flush or priority grant.
  always_comb begin
    ptr_d = ptr_q;
    if (found && !prio_win) begin
      if (win_idx == SRC_WIDTH'(NUM_REQ - 1)) ptr_d = '0;
      else                                    ptr_d = win_idx + SRC_WIDTH'(1);
    end
  end

  // Load the broadcast register from the winner; payload holds when nothing is granted.
  always_comb begin
    cdb_valid_d = found;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    if (found) begin
      cdb_tag_d  = sel_tag;
      cdb_data_d = sel_data;
      cdb_src_d  = win_idx;
    end
  end

  // State registers, cleared asynchronously so a reset mid-broadcast kills it at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;

endmodule
